score_judge: RTL

Judgment and scoring stage placed directly upstream of the 8-bit score register. It times each player key press against the note-arrival pulse from the note sequencer, grades it PERFECT/GOOD/MISS, tracks a saturating combo count and produces the next score value. The score register captures that value on every clock. Output `I_next` connects to the score register's `I` input.

---
 rtl/score_judge.sv | 125 ++++++++++++
 1 files changed

// File: rtl/score_judge.sv
// Note judgment and scoring stage: grades key presses against note arrival,
// tracks a saturating combo and produces the next score register value.
module score_judge #(
  parameter int PERFECT_WIN = 4,
  parameter int GOOD_WIN    = 12,
  parameter int MISS_WIN    = 20,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int COMBO_BONUS = 8
) (
  input  logic       C,
  input  logic       INIT,
  input  logic       note_hit,
  input  logic       key_press,
  output logic [7:0] I_next,
  output logic       score_load,
  output logic [1:0] grade,
  output logic       grade_valid,
  output logic [3:0] combo
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OPEN   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [1:0] G_PERFECT = 2'b01;
  localparam logic [1:0] G_GOOD    = 2'b10;
  localparam logic [1:0] G_MISS    = 2'b11;

  localparam logic [7:0] P_WIN = 8'(PERFECT_WIN);
  localparam logic [7:0] G_WIN = 8'(GOOD_WIN);
  localparam logic [7:0] M_WIN = 8'(MISS_WIN);
  localparam logic [8:0] P_PTS = 9'(PERFECT_PTS);
  localparam logic [8:0] G_PTS = 9'(GOOD_PTS);
  localparam logic [3:0] C_BON = 4'(COMBO_BONUS);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [1:0] g;
  logic       pending;
  logic [1:0] key_grade;
  logic [8:0] sum;
  logic [7:0] sat;

  always_comb begin
    key_grade = G_MISS;
    if (cnt <= P_WIN)
      key_grade = G_PERFECT;
    else if (cnt <= G_WIN)
      key_grade = G_GOOD;
  end

  // bonus uses the combo value before this hit is counted
  always_comb begin
    sum = {1'b0, I_next}
        + ((g == G_PERFECT) ? P_PTS : G_PTS)
        + {8'd0, (combo >= C_BON)};
    sat = sum[8] ? 8'hff : sum[7:0];
  end

  always_ff @(posedge C or posedge INIT) begin
    if (INIT) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      g           <= 2'b00;
      pending     <= 1'b0;
      I_next      <= 8'd0;
      combo       <= 4'd0;
      grade       <= 2'b00;
      score_load  <= 1'b0;
      grade_valid <= 1'b0;
    end else begin
      score_load  <= 1'b0;
      grade_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (note_hit && key_press) begin
            g     <= G_PERFECT;
            state <= UPDATE;
          end else if (note_hit) begin
            cnt   <= 8'd0;
            state <= OPEN;
          end
        end
        OPEN: begin
          if (key_press) begin
            g       <= key_grade;
            pending <= pending | note_hit;
            state   <= UPDATE;
          end else if (note_hit) begin
            g       <= G_MISS;
            pending <= 1'b1;
            state   <= UPDATE;
          end else if (cnt == M_WIN) begin
            g     <= G_MISS;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        UPDATE: begin
          grade       <= g;
          score_load  <= 1'b1;
          grade_valid <= 1'b1;
          if (g == G_MISS) begin
            combo <= 4'd0;
          end else begin
            I_next <= sat;
            combo  <= (combo == 4'd15) ? 4'd15 : combo + 4'd1;
          end
          // a note arriving during UPDATE opens its window on this edge
          if (pending || note_hit) begin
            cnt     <= 8'd0;
            pending <= 1'b0;
            state   <= OPEN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
